ym_ssg_multi: RTL and testbench

Parametrised SSG (PSG) sound generator for the YM2610 audio model. It provides CHANNELS square-wave tone channels, one shared 17-bit LFSR noise source and one shared envelope generator that implements all 16 AY/YM envelope shapes. A write strobe restarts the envelope. The block produces a registered, summed unsigned level for the audio mixer and sits between the YM register file and the DAC/mixer model.

---
 rtl/ym_ssg_multi.sv | 207 ++++++++++++++++++++
 tb/tb_ym_ssg_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ym_ssg_multi.sv
// -----------------------------------------------------------------------------
// ym_ssg_multi
// SSG (PSG) sound generator for the YM2610 audio model. It has CHANNELS
// square-wave tone channels, one shared 17-bit LFSR noise source and one shared
// envelope generator covering all 16 AY/YM envelope shapes. Its output is a
// registered, summed, unsigned level for the audio mixer.
//
// Ports
//   PHI_S         in   SSG clock; all state changes on the rising edge
//   RESET         in   asynchronous, active-high reset
//   SSG_FREQ      in   tone half-periods, channel n at [n*TONE_W +: TONE_W]
//   SSG_NOISE     in   noise shift period
//   SSG_EN        in   active-low enables: bit n tone n, bit CHANNELS+n noise n
//   SSG_VOL       in   per channel 5 bits: bit4 use envelope, bits3:0 level
//   SSG_ENV_FREQ  in   envelope step period
//   SSG_ENV       in   envelope shape {CONT, ATT, ALT, HOLD}
//   ENV_WR        in   one-cycle strobe that restarts the envelope
//   ANA           out  registered sum of channel levels
// -----------------------------------------------------------------------------
module ym_ssg_multi #(
   parameter int CHANNELS = 3,
   parameter int TONE_W   = 12,
   parameter int ENV_W    = 16,
   parameter int OUT_W    = 4 + $clog2(CHANNELS + 1)
) (
   input  logic                       PHI_S,
   input  logic                       RESET,
   input  logic [CHANNELS*TONE_W-1:0] SSG_FREQ,
   input  logic [4:0]                 SSG_NOISE,
   input  logic [2*CHANNELS-1:0]      SSG_EN,
   input  logic [CHANNELS*5-1:0]      SSG_VOL,
   input  logic [ENV_W-1:0]           SSG_ENV_FREQ,
   input  logic [3:0]                 SSG_ENV,
   input  logic                       ENV_WR,
   output logic [OUT_W-1:0]           ANA
);

   localparam logic [TONE_W-1:0] TONE_ZERO = {TONE_W{1'b0}};
   localparam logic [TONE_W-1:0] TONE_ONE  = {{(TONE_W-1){1'b0}}, 1'b1};
   localparam logic [ENV_W-1:0]  ENV_ZERO  = {ENV_W{1'b0}};
   localparam logic [ENV_W-1:0]  ENV_ONE   = {{(ENV_W-1){1'b0}}, 1'b1};

   // Tone generators
   logic [TONE_W-1:0]   r_tone_cnt [CHANNELS];
   logic [CHANNELS-1:0] r_osc;
   logic [TONE_W-1:0]   w_tone_lim [CHANNELS];
   logic [CHANNELS-1:0] w_tone_fire;

   // Noise generator
   logic [4:0]          r_noise_cnt;
   logic [16:0]         r_lfsr;
   logic                r_noise;
   logic [4:0]          w_noise_lim;
   logic                w_noise_fire;

   // Envelope generator
   logic [ENV_W-1:0]    r_env_cnt;
   logic                r_env_run;
   logic [3:0]          r_env_step;
   logic [3:0]          r_env_att;
   logic [ENV_W-1:0]    w_env_lim;
   logic                w_env_fire;
   logic [3:0]          w_env_vol;

   // Mixer
   logic [3:0]          w_level [CHANNELS];
   logic [OUT_W-1:0]    w_sum;
   logic [OUT_W-1:0]    r_ana;

   // Period compare for the tone counters. The limit is max(P,1)-1, and the
   // >= compare makes a lowered period fire on the very next edge.
   always_comb begin
      for (int n = 0; n < CHANNELS; n++) begin
         if (SSG_FREQ[n*TONE_W +: TONE_W] == TONE_ZERO) begin
            w_tone_lim[n] = TONE_ZERO;
         end else begin
            w_tone_lim[n] = SSG_FREQ[n*TONE_W +: TONE_W] - TONE_ONE;
         end
         w_tone_fire[n] = (r_tone_cnt[n] >= w_tone_lim[n]);
      end
   end

   // Tone counters and oscillator flip-flops.
   always_ff @(posedge PHI_S or posedge RESET) begin
      if (RESET) begin
         for (int n = 0; n < CHANNELS; n++) begin
            r_tone_cnt[n] <= TONE_ZERO;
         end
         r_osc <= {CHANNELS{1'b0}};
      end else begin
         for (int n = 0; n < CHANNELS; n++) begin
            if (w_tone_fire[n]) begin
               r_tone_cnt[n] <= TONE_ZERO;
               r_osc[n]      <= ~r_osc[n];
            end else begin
               r_tone_cnt[n] <= r_tone_cnt[n] + TONE_ONE;
            end
         end
      end
   end

   // Period compare for the noise counter.
   always_comb begin
      if (SSG_NOISE == 5'd0) begin
         w_noise_lim = 5'd0;
      end else begin
         w_noise_lim = SSG_NOISE - 5'd1;
      end
      w_noise_fire = (r_noise_cnt >= w_noise_lim);
   end

   // Noise counter and LFSR; NOISE takes the bit that is shifted out.
   always_ff @(posedge PHI_S or posedge RESET) begin
      if (RESET) begin
         r_noise_cnt <= 5'd0;
         r_lfsr      <= 17'h00001;
         r_noise     <= 1'b0;
      end else begin
         if (w_noise_fire) begin
            r_noise_cnt <= 5'd0;
            r_lfsr      <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
            r_noise     <= r_lfsr[0];
         end else begin
            r_noise_cnt <= r_noise_cnt + 5'd1;
         end
      end
   end

   // Envelope event: only counts while running.
   always_comb begin
      if (SSG_ENV_FREQ == ENV_ZERO) begin
         w_env_lim = ENV_ZERO;
      end else begin
         w_env_lim = SSG_ENV_FREQ - ENV_ONE;
      end
      w_env_fire = r_env_run & (r_env_cnt >= w_env_lim);
      w_env_vol  = r_env_step ^ r_env_att;
   end

   // Envelope state. A restart wins over a same-cycle event; the shape bits
   // are read at each event rather than latched at the restart.
   always_ff @(posedge PHI_S or posedge RESET) begin
      if (RESET) begin
         r_env_cnt  <= ENV_ZERO;
         r_env_run  <= 1'b0;
         r_env_step <= 4'd0;
         r_env_att  <= 4'd0;
      end else if (ENV_WR) begin
         r_env_cnt  <= ENV_ZERO;
         r_env_run  <= 1'b1;
         r_env_step <= 4'hF;
         r_env_att  <= {4{SSG_ENV[2]}};
      end else if (r_env_run) begin
         if (w_env_fire) begin
            r_env_cnt <= ENV_ZERO;
            if (r_env_step != 4'd0) begin
               r_env_step <= r_env_step - 4'd1;
            end else if (!SSG_ENV[3]) begin
               // one-shot shapes always end at silence
               r_env_att <= 4'd0;
               r_env_run <= 1'b0;
            end else begin
               if (SSG_ENV[1]) begin
                  r_env_att <= ~r_env_att;
               end
               if (SSG_ENV[0]) begin
                  r_env_run <= 1'b0;
               end else begin
                  r_env_step <= 4'hF;
               end
            end
         end else begin
            r_env_cnt <= r_env_cnt + ENV_ONE;
         end
      end
   end

   // Channel gating and level summation. Disabled sources force their gate
   // term open, so a channel with both sources disabled outputs its level.
   always_comb begin
      w_sum = {OUT_W{1'b0}};
      for (int n = 0; n < CHANNELS; n++) begin
         if ((r_osc[n] | SSG_EN[n]) & (r_noise | SSG_EN[CHANNELS+n])) begin
            if (SSG_VOL[n*5+4]) begin
               w_level[n] = w_env_vol;
            end else begin
               w_level[n] = SSG_VOL[n*5 +: 4];
            end
         end else begin
            w_level[n] = 4'd0;
         end
         w_sum = w_sum + OUT_W'(w_level[n]);
      end
   end

   // Output register.
   always_ff @(posedge PHI_S or posedge RESET) begin
      if (RESET) begin
         r_ana <= {OUT_W{1'b0}};
      end else begin
         r_ana <= w_sum;
      end
   end

   assign ANA = r_ana;

endmodule

// File: tb/tb_ym_ssg_multi.sv
module tb_ym_ssg_multi;

   logic        PHI_S;
   logic        RESET;
   logic [35:0] SSG_FREQ;
   logic [4:0]  SSG_NOISE;
   logic [5:0]  SSG_EN;
   logic [14:0] SSG_VOL;
   logic [15:0] SSG_ENV_FREQ;
   logic [3:0]  SSG_ENV;
   logic        ENV_WR;
   logic [5:0]  ANA;

   int checks   = 0;
   int failures = 0;
   logic [5:0] sb_q[$];

   ym_ssg_multi dut (
      .PHI_S        (PHI_S),
      .RESET        (RESET),
      .SSG_FREQ     (SSG_FREQ),
      .SSG_NOISE    (SSG_NOISE),
      .SSG_EN       (SSG_EN),
      .SSG_VOL      (SSG_VOL),
      .SSG_ENV_FREQ (SSG_ENV_FREQ),
      .SSG_ENV      (SSG_ENV),
      .ENV_WR       (ENV_WR),
      .ANA          (ANA)
   );

   initial PHI_S = 1'b0;
   always #5 PHI_S = ~PHI_S;

   task automatic chk(input logic [5:0] obs, input logic [5:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // push the expected ANA for the coming edge, then pop and compare after it
   task automatic tick(input logic [5:0] exp, input string tag);
      sb_q.push_back(exp);
      @(posedge PHI_S);
      #1;
      chk(ANA, sb_q.pop_front(), tag);
   endtask

   // reset with the current inputs, check reset state, release just after an edge
   task automatic do_reset();
      RESET  = 1'b1;
      ENV_WR = 1'b0;
      @(posedge PHI_S);
      #1;
      chk(ANA, 6'd0, "reset_ana");
      chk({5'd0, dut.r_env_run}, 6'd0, "reset_run");
      RESET = 1'b0;
   endtask

   function automatic logic [5:0] tri_vol(input int m);
      int t;
      t = m % 32;
      return (t < 16) ? 6'(15 - t) : 6'(t - 16);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [16:0] ref_lfsr;
      logic        ref_noise;

      RESET = 1'b1; ENV_WR = 1'b0;
      SSG_FREQ = 36'd0; SSG_NOISE = 5'd0; SSG_EN = 6'b111111;
      SSG_VOL = 15'd0; SSG_ENV_FREQ = 16'd0; SSG_ENV = 4'd0;

      // tone ch0 period 2, other channels silent
      SSG_FREQ = {12'd0, 12'd0, 12'd2}; SSG_EN = 6'b111110;
      SSG_VOL  = {5'h00, 5'h00, 5'h0F};
      do_reset();
      for (int k = 1; k <= 12; k++) tick((((k - 1) / 2) % 2) ? 6'd15 : 6'd0, "tone_p2");

      // period lowered mid-count fires on the next edge
      SSG_FREQ = {12'd0, 12'd0, 12'd10};
      do_reset();
      for (int k = 1; k <= 5; k++) tick(6'd0, "tone_p10");
      SSG_FREQ = {12'd0, 12'd0, 12'd2};
      tick(6'd0,  "tone_lower_e6");
      tick(6'd15, "tone_lower_e7");
      tick(6'd15, "tone_lower_e8");
      tick(6'd0,  "tone_lower_e9");

      // P=0 on all channels toggles every edge
      SSG_FREQ = 36'd0; SSG_EN = 6'b111000;
      SSG_VOL  = {5'h0F, 5'h0F, 5'h0F};
      do_reset();
      for (int k = 1; k <= 8; k++) tick(((k - 1) % 2) ? 6'd45 : 6'd0, "tone_p0_all");

      // noise only on ch1, N=1, against a reference LFSR
      SSG_NOISE = 5'd1; SSG_EN = 6'b101111;
      SSG_VOL   = {5'h00, 5'h0F, 5'h00};
      do_reset();
      ref_lfsr  = 17'h00001;
      ref_noise = 1'b0;
      for (int k = 1; k <= 1001; k++) begin
         tick(ref_noise ? 6'd15 : 6'd0, "noise_seq");
         ref_noise = ref_lfsr[0];
         ref_lfsr  = {ref_lfsr[0] ^ ref_lfsr[3], ref_lfsr[16:1]};
      end

      // envelope shape 1101, E=1: 0..15 then hold 15
      SSG_NOISE = 5'd0; SSG_EN = 6'b111111;
      SSG_VOL = {5'h00, 5'h00, 5'h10}; SSG_ENV = 4'b1101; SSG_ENV_FREQ = 16'd1;
      do_reset();
      tick(6'd0, "env1101_idle");
      ENV_WR = 1'b1;
      tick(6'd0, "env1101_wr");
      ENV_WR = 1'b0;
      for (int i = 0; i <= 20; i++) tick((i > 15) ? 6'd15 : 6'(i), "env1101_ramp");
      chk({5'd0, dut.r_env_run}, 6'd0, "env1101_run_off");

      // envelope shape 1010, E=2: triangle, then restart mid-ramp on an event edge
      SSG_ENV = 4'b1010; SSG_ENV_FREQ = 16'd2;
      do_reset();
      tick(6'd0, "env1010_idle");
      ENV_WR = 1'b1;
      tick(6'd0, "env1010_wr");
      ENV_WR = 1'b0;
      for (int j = 0; j <= 50; j++) tick(tri_vol(j / 2), "env1010_tri");
      ENV_WR = 1'b1;
      tick(tri_vol(25), "env1010_rewr");
      ENV_WR = 1'b0;
      for (int j = 0; j <= 39; j++) tick(tri_vol(j / 2), "env1010_restart");
      chk({5'd0, dut.r_env_run}, 6'd1, "env1010_run_on");

      // envelope shape 0100, E=1: 0..15 then 0 held
      SSG_ENV = 4'b0100; SSG_ENV_FREQ = 16'd1;
      do_reset();
      tick(6'd0, "env0100_idle");
      ENV_WR = 1'b1;
      tick(6'd0, "env0100_wr");
      ENV_WR = 1'b0;
      for (int i = 0; i <= 20; i++) tick((i > 15) ? 6'd0 : 6'(i), "env0100_ramp");
      chk({5'd0, dut.r_env_run}, 6'd0, "env0100_run_off");

      // restart, then reset asynchronously mid-ramp
      ENV_WR = 1'b1;
      tick(6'd0, "env0100_wr2");
      ENV_WR = 1'b0;
      for (int i = 0; i <= 4; i++) tick(6'(i), "env0100_ramp2");
      #3;
      RESET = 1'b1;
      #1;
      chk(ANA, 6'd0, "async_reset_ana");
      chk({5'd0, dut.r_env_run}, 6'd0, "async_reset_run");
      ENV_WR = 1'b1;
      @(posedge PHI_S);
      #1;
      chk({5'd0, dut.r_env_run}, 6'd0, "wr_in_reset_run");
      chk(ANA, 6'd0, "wr_in_reset_ana");
      ENV_WR = 1'b0;
      RESET  = 1'b0;
      for (int i = 0; i < 3; i++) tick(6'd0, "after_reset_idle");
      chk({5'd0, dut.r_env_run}, 6'd0, "after_reset_run");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
